// File: rtl/arm_pkg.sv
// arm_pkg: shared LEGv8 control word, register constants and operand-use helper
package arm_pkg;
    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);
    localparam logic [4:0] XZR = 5'd31;

    // R-type ALU ops, stores and CBZ read the second register port
    function automatic logic uses_rs2(ctrl_t c);
        return !c.alusrc || c.memwrite || c.branch;
    endfunction
endpackage

// File: rtl/id_ex_stage_wb_bypass.sv
// wb_bypass: selects next ID/EX operand, forwarding write-back data when WB_BYPASS_EN is defined
module wb_bypass
    import arm_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         stored,
    input  logic [4:0]   addr_d,
    input  logic [N-1:0] data_d,
    input  logic [4:0]   addr_e,
    input  logic [N-1:0] data_e,
    input  logic         wb_we,
    input  logic [4:0]   wb_wa,
    input  logic [N-1:0] wb_wd,
    output logic [N-1:0] q
);
`ifdef WB_BYPASS_EN
    logic [4:0]   a;
    logic [N-1:0] d;
    always_comb begin
        a = stored ? addr_e : addr_d;
        d = stored ? data_e : data_d;
        q = (wb_we && wb_wa != XZR && wb_wa == a) ? wb_wd : d;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{addr_d, addr_e, wb_we, wb_wa, wb_wd};
    assign q = stored ? data_e : data_d;
`endif
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: LEGv8 ID/EX register with load-use bubble insertion; WB_BYPASS_EN enables write-back forwarding
module id_ex_stage
    import arm_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_d,
    input  logic [4:0]   ra1_d,
    input  logic [4:0]   ra2_d,
    input  logic [4:0]   wa3_d,
    input  logic [N-1:0] rd1_d,
    input  logic [N-1:0] rd2_d,
    input  logic [N-1:0] imm_d,
    input  logic [N-1:0] pc_d,
    input  ctrl_t        ctrl_d,
    input  logic         hold_e,
    input  logic         flush_e,
    input  logic         wb_we,
    input  logic [4:0]   wb_wa,
    input  logic [N-1:0] wb_wd,
    output logic         stall_req_d,
    output logic         valid_e,
    output logic [4:0]   ra1_e,
    output logic [4:0]   ra2_e,
    output logic [4:0]   wa3_e,
    output logic [N-1:0] rd1_e,
    output logic [N-1:0] rd2_e,
    output logic [N-1:0] imm_e,
    output logic [N-1:0] pc_e,
    output ctrl_t        ctrl_e
);
    logic         hazard;
    logic [N-1:0] q1, q2;

    always_comb begin
        hazard = ctrl_e.memread && valid_e && valid_d && wa3_e != XZR &&
                 (wa3_e == ra1_d || (wa3_e == ra2_d && uses_rs2(ctrl_d)));
        stall_req_d = hazard || hold_e;
    end

    wb_bypass #(.N(N)) u_byp1 (
        .stored(hold_e), .addr_d(ra1_d), .data_d(rd1_d), .addr_e(ra1_e), .data_e(rd1_e),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .q(q1)
    );

    wb_bypass #(.N(N)) u_byp2 (
        .stored(hold_e), .addr_d(ra2_d), .data_d(rd2_d), .addr_e(ra2_e), .data_e(rd2_e),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .q(q2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_e <= 1'b0;
            ra1_e   <= '0;
            ra2_e   <= '0;
            wa3_e   <= '0;
            rd1_e   <= '0;
            rd2_e   <= '0;
            imm_e   <= '0;
            pc_e    <= '0;
            ctrl_e  <= '0;
        end else begin
            rd1_e <= q1;
            rd2_e <= q2;
            if (!hold_e) begin
                valid_e <= valid_d && !(flush_e || hazard);
                ctrl_e  <= (flush_e || hazard) ? '0 : ctrl_d;
                ra1_e   <= ra1_d;
                ra2_e   <= ra2_d;
                wa3_e   <= wa3_d;
                imm_e   <= imm_d;
                pc_e    <= pc_d;
            end
        end
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 64-bit LEGv8 pipelined core. It consumes the register file's asynchronous read data (rd1/rd2) together with decode-stage immediates and control. It registers these for the execute stage and detects load-use hazards, inserting one bubble per hazard. An optional write-back bypass resolves same-cycle write/read collisions on the register file.

## Interface
Parameters:
- N, 64, datapath width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- valid_d  in  1  decode stage holds a real instruction.
- ra1_d, ra2_d  in  5  source register addresses as presented to the register file.
- wa3_d  in  5  destination register address.
- rd1_d, rd2_d  in  N  register file read data.
- imm_d  in  N  sign-extended immediate.
- pc_d  in  N  instruction PC.
- ctrl_d  in  CTRL_W  decoded control word (ctrl_t from package).
- hold_e  in  1  downstream stall: freeze the ID/EX register.
- flush_e  in  1  branch taken: kill the instruction entering EX.
- wb_we  in  1  write-back write enable (same signal driving register file we3).
- wb_wa  in  5  write-back address.
- wb_wd  in  N  write-back data.
- stall_req_d  out  1  combinational; freeze PC and IF/ID this cycle.
- valid_e  out  1  EX stage holds a real instruction.
- ra1_e, ra2_e, wa3_e  out  5  registered addresses.
- rd1_e, rd2_e, imm_e, pc_e  out  N  registered operands.
- ctrl_e  out  CTRL_W  registered control word.

## Operation
- Register 31 (XZR) is never a hazard source, never a bypass target, and never a bypass source.
- Load-use hazard: ctrl_e.memread & valid_e & valid_d & wa3_e≠31 & (wa3_e==ra1_d | (wa3_e==ra2_d & ctrl_d uses rs2)). rs2 use is given by the package function uses_rs2(ctrl_d).
- stall_req_d = hazard | hold_e.
- Next-state priority at each rising edge:
  - reset: valid_e=0, all data, address and control outputs are 0.
  - else if hold_e: all fields hold, except for the bypass refresh described below.
  - else if flush_e or hazard: bubble. valid_e=0 and ctrl_e=0 (no regwrite, memwrite or memread). The other fields are don't-care and are loaded as in the load case.
  - else: load all _d fields; valid_e=valid_d.
- A bubble with ctrl_e=0 clears the hazard condition on the following cycle, so each load-use hazard stalls exactly one cycle.
- reset asserted mid-operation overrides hold_e, flush_e and hazard in the same cycle.

## Timing
- One-cycle latency from _d inputs to _e outputs. All _e outputs are registered.
- stall_req_d is purely combinational from the current _e state and the _d inputs. There is no registered path.
- The register file writes on the posedge and reads asynchronously. A read in the same cycle as a write to the same address therefore returns the old value, and the bypass described under Configuration covers this.
- flush_e and hazard in the same cycle: a single bubble results, and stall_req_d is still asserted.
- hold_e and flush_e in the same cycle: hold wins. The flush must be re-presented by the control unit.

## Configuration
- WB_BYPASS_EN defined:
  - On load, rd1_e takes wb_wd when wb_we & wb_wa≠31 & wb_wa==ra1_d. Otherwise it takes rd1_d. rd2_e follows the same rule with ra2_d.
  - While holding, a stored rd1_e or rd2_e is overwritten with wb_wd when wb_we & wb_wa≠31 & wb_wa matches ra1_e or ra2_e respectively. This stops a held entry going stale.
- WB_BYPASS_EN undefined:
  - rd1_d and rd2_d are captured raw and held values never change.
  - The hazard unit must cover write-back collisions externally.
  - Port list is identical in both builds.

## Structure
- Shared package (arm_pkg):
  - ctrl_t packed struct with fields reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0].
  - CTRL_W = $bits(ctrl_t).
  - XZR = 5'd31.
  - Function uses_rs2(ctrl_t).
- One sub-module is natural: wb_bypass, instantiated twice (operand 1 and operand 2).
  - Inputs: address, data, stored flag, wb_we, wb_wa, wb_wd.
  - Output: the selected data.
  - It compiles to a pass-through when WB_BYPASS_EN is undefined.

## Test plan
- Reset: assert reset for 2 cycles with arbitrary _d inputs. Required: valid_e=0, ctrl_e=0, rd1_e=0 and stall_req_d=0 after the edge.
- Straight load: valid_d=1, ra1_d=3, rd1_d=64'h33, imm_d=8. Required next cycle: valid_e=1, rd1_e=64'h33, imm_e=8, with no stall.
- Load-use:
  - Setup: EX holds LDUR with wa3_e=5 and memread=1. ID holds ADD with ra1_d=5.
  - Required: stall_req_d=1 in that cycle; next cycle valid_e=0 and ctrl_e=0; the cycle after, the ADD loads.
  - Repeat with wa3_e=31. Required: no stall.
- Flush during hazard: flush_e=1 with a hazard active. Required: exactly one bubble and stall_req_d=1.
- Bypass load (WB_BYPASS_EN defined): wb_we=1, wb_wa=7, wb_wd=64'hAB, ra2_d=7, rd2_d=64'h07. Required: rd2_e=64'hAB. Without the macro: rd2_e=64'h07. With wb_wa=31: rd2_e=rd2_d.
- Held refresh: hold_e=1 for 3 cycles with ra1_e=9, and wb writes X9=64'h99 in the second cycle. With WB_BYPASS_EN, rd1_e=64'h99 from the third cycle on; without it, rd1_e is unchanged. In both builds valid_e and ctrl_e are unchanged throughout.
